// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment scan driver. Outputs are registered and trail the scan index by one clk.
// There is no backpressure. en=0 freezes the scan and turns every segment and anode off.
module seg7_scan_driver #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int HEX_MODE    = 0,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    input  logic                    blank_lz,
    output logic [7:0]              segments_out,
    output logic [NUM_DIGITS-1:0]   anode_out,
    output logic                    frame_tick
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [7:0] SEG_OFF = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [NUM_DIGITS-1:0] AN_OFF = (ACTIVE_LOW != 0) ? '1 : '0;

    logic [PRE_W-1:0]        presc_q, presc_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] snap_digits_q, snap_digits_d;
    logic [NUM_DIGITS-1:0]   snap_dp_q, snap_dp_d;
    logic                    snap_blz_q, snap_blz_d;
    logic                    load_pend_q, load_pend_d;
    logic                    frame_tick_q, frame_tick_d;
    logic [7:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;

    logic                    advance;
    logic                    load;
    logic [4*NUM_DIGITS-1:0] disp_digits;
    logic [NUM_DIGITS-1:0]   disp_dp;
    logic                    disp_blz;
    logic [3:0]              cur_code;
    logic                    lz_blank;
    logic [7:0]              seg_act;
    logic [NUM_DIGITS-1:0]   an_act;

    function automatic logic [7:0] glyph(input logic [3:0] code);
        logic [7:0] g;
        case (code)
            4'h0:    g = 8'hFC;
            4'h1:    g = 8'h60;
            4'h2:    g = 8'hDA;
            4'h3:    g = 8'hF2;
            4'h4:    g = 8'h66;
            4'h5:    g = 8'hB6;
            4'h6:    g = 8'hBE;
            4'h7:    g = 8'hE0;
            4'h8:    g = 8'hFE;
            4'h9:    g = 8'hF6;
            4'hA:    g = (HEX_MODE != 0) ? 8'hEE : 8'h00;
            4'hB:    g = (HEX_MODE != 0) ? 8'h3E : 8'h00;
            4'hC:    g = (HEX_MODE != 0) ? 8'h9C : 8'h00;
            4'hD:    g = (HEX_MODE != 0) ? 8'h7A : 8'h00;
            4'hE:    g = (HEX_MODE != 0) ? 8'h9E : 8'h00;
            default: g = (HEX_MODE != 0) ? 8'h8E : 8'h00;
        endcase
        return g;
    endfunction

    always_comb begin
        presc_d       = presc_q;
        idx_d         = idx_q;
        snap_digits_d = snap_digits_q;
        snap_dp_d     = snap_dp_q;
        snap_blz_d    = snap_blz_q;
        load_pend_d   = load_pend_q;
        frame_tick_d  = 1'b0;
        seg_d         = SEG_OFF;
        an_d          = AN_OFF;

        advance = (presc_q == PRE_LAST);
        load    = load_pend_q | (advance & (idx_q == IDX_LAST));

        // The first slot after reset belongs to the frame being captured on this same edge.
        disp_digits = load_pend_q ? digits   : snap_digits_q;
        disp_dp     = load_pend_q ? dp_mask  : snap_dp_q;
        disp_blz    = load_pend_q ? blank_lz : snap_blz_q;

        cur_code = disp_digits[{idx_q, 2'b00} +: 4];
        lz_blank = disp_blz && (idx_q != '0) && ((disp_digits >> {idx_q, 2'b00}) == '0);
        seg_act  = lz_blank ? 8'h00 : glyph(cur_code);
        seg_act[0] = disp_dp[idx_q];
        an_act   = '0;
        an_act[idx_q] = 1'b1;

        if (en) begin
            presc_d = advance ? '0 : presc_q + PRE_W'(1);
            if (advance) begin
                idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
            end
            if (load) begin
                snap_digits_d = digits;
                snap_dp_d     = dp_mask;
                snap_blz_d    = blank_lz;
                load_pend_d   = 1'b0;
                frame_tick_d  = 1'b1;
            end
            seg_d = (ACTIVE_LOW != 0) ? ~seg_act : seg_act;
            an_d  = (ACTIVE_LOW != 0) ? ~an_act  : an_act;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_q       <= '0;
            idx_q         <= '0;
            snap_digits_q <= '0;
            snap_dp_q     <= '0;
            snap_blz_q    <= 1'b0;
            load_pend_q   <= 1'b1;
            frame_tick_q  <= 1'b0;
            seg_q         <= SEG_OFF;
            an_q          <= AN_OFF;
        end else begin
            presc_q       <= presc_d;
            idx_q         <= idx_d;
            snap_digits_q <= snap_digits_d;
            snap_dp_q     <= snap_dp_d;
            snap_blz_q    <= snap_blz_d;
            load_pend_q   <= load_pend_d;
            frame_tick_q  <= frame_tick_d;
            seg_q         <= seg_d;
            an_q          <= an_d;
        end
    end

    assign segments_out = seg_q;
    assign anode_out    = an_q;
    assign frame_tick   = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: cycle scoreboard plus directed scan, blanking, hex, enable and reset cases.
module tb_seg7_scan_driver;

    localparam int ND = 4;
    localparam int RD = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [15:0] digits;
    logic [3:0]  dp_mask;
    logic        blank_lz;
    logic [7:0]  seg0, seg1, seg2;
    logic [3:0]  an0, an1, an2;
    logic        tick0, tick1, tick2;

    always #5 clk = ~clk;

    seg7_scan_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .HEX_MODE(0), .ACTIVE_LOW(1)) u_dec (
        .clk(clk), .rst_n(rst_n), .en(en), .digits(digits), .dp_mask(dp_mask), .blank_lz(blank_lz),
        .segments_out(seg0), .anode_out(an0), .frame_tick(tick0));

    seg7_scan_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .HEX_MODE(1), .ACTIVE_LOW(1)) u_hex (
        .clk(clk), .rst_n(rst_n), .en(en), .digits(digits), .dp_mask(dp_mask), .blank_lz(blank_lz),
        .segments_out(seg1), .anode_out(an1), .frame_tick(tick1));

    seg7_scan_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .HEX_MODE(1), .ACTIVE_LOW(0)) u_hi (
        .clk(clk), .rst_n(rst_n), .en(en), .digits(digits), .dp_mask(dp_mask), .blank_lz(blank_lz),
        .segments_out(seg2), .anode_out(an2), .frame_tick(tick2));

    typedef struct packed {
        logic       tick;
        logic [3:0] an;
        logic [7:0] seg_dec;
        logic [7:0] seg_hex;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    int          m_presc, m_idx;
    logic [15:0] m_dig;
    logic [3:0]  m_dp;
    logic        m_blz, m_pend;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic logic [7:0] ref_glyph(input logic [3:0] c, input bit hex);
        case (c)
            4'h0: return 8'hFC;
            4'h1: return 8'h60;
            4'h2: return 8'hDA;
            4'h3: return 8'hF2;
            4'h4: return 8'h66;
            4'h5: return 8'hB6;
            4'h6: return 8'hBE;
            4'h7: return 8'hE0;
            4'h8: return 8'hFE;
            4'h9: return 8'hF6;
            4'hA: return hex ? 8'hEE : 8'h00;
            4'hB: return hex ? 8'h3E : 8'h00;
            4'hC: return hex ? 8'h9C : 8'h00;
            4'hD: return hex ? 8'h7A : 8'h00;
            4'hE: return hex ? 8'h9E : 8'h00;
            default: return hex ? 8'h8E : 8'h00;
        endcase
    endfunction

    // Expected outputs after each rising edge, computed from what the inputs were at that edge.
    task automatic model_step();
        exp_t        e;
        logic        ld, dblz;
        logic [15:0] dd;
        logic [3:0]  ddp, code, onehot;
        logic [7:0]  gd, gh;
        int          h;
        e.tick = 1'b0;
        e.an = 4'hF;
        e.seg_dec = 8'hFF;
        e.seg_hex = 8'hFF;
        if (!rst_n) begin
            m_presc = 0;
            m_idx = 0;
            m_dig = '0;
            m_dp = '0;
            m_blz = 1'b0;
            m_pend = 1'b1;
        end else if (en) begin
            dd   = m_pend ? digits : m_dig;
            ddp  = m_pend ? dp_mask : m_dp;
            dblz = m_pend ? blank_lz : m_blz;
            ld   = m_pend || (m_presc == RD - 1 && m_idx == ND - 1);
            code = dd[4*m_idx +: 4];
            h = -1;
            for (int i = 0; i < ND; i++) if (dd[4*i +: 4] != 4'd0) h = i;
            gd = ref_glyph(code, 1'b0);
            gh = ref_glyph(code, 1'b1);
            if (dblz && m_idx > 0 && m_idx > h) begin
                gd = 8'h00;
                gh = 8'h00;
            end
            gd[0] = ddp[m_idx];
            gh[0] = ddp[m_idx];
            onehot = 4'b0001 << m_idx;
            e.tick = ld;
            e.an = ~onehot;
            e.seg_dec = ~gd;
            e.seg_hex = ~gh;
            if (m_presc == RD - 1) begin
                m_presc = 0;
                m_idx = (m_idx + 1) % ND;
            end else begin
                m_presc = m_presc + 1;
            end
            if (ld) begin
                m_dig = digits;
                m_dp = dp_mask;
                m_blz = blank_lz;
                m_pend = 1'b0;
            end
        end
        sb.push_back(e);
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial begin : sb_check
        exp_t       e;
        logic [7:0] s_inv;
        logic [3:0] a_inv;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                s_inv = ~e.seg_hex;
                a_inv = ~e.an;
                chk("sb_tick", 16'(tick0), 16'(e.tick));
                chk("sb_an", 16'(an0), 16'(e.an));
                chk("sb_seg_dec", 16'(seg0), 16'(e.seg_dec));
                chk("sb_seg_hex", 16'(seg1), 16'(e.seg_hex));
                chk("sb_an_hex", 16'(an1), 16'(e.an));
                chk("sb_tick_hi", 16'(tick2), 16'(e.tick));
                chk("sb_seg_hi", 16'(seg2), 16'(s_inv));
                chk("sb_an_hi", 16'(an2), 16'(a_inv));
            end
        end
    end

    task automatic wait_tick();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tick0 !== 1'b1 && n < 40);
        if (tick0 !== 1'b1) chk("tick_timeout", 16'(tick0), 16'd1);
    endtask

    task automatic wait_an(input logic [3:0] target);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (an0 !== target && n < 40);
        if (an0 !== target) chk("an_timeout", 16'(an0), 16'(target));
    endtask

    initial begin : stim
        logic [3:0] ea;
        logic [7:0] es;
        rst_n = 1'b0;
        en = 1'b1;
        digits = 16'h1234;
        dp_mask = 4'h0;
        blank_lz = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_seg", 16'(seg0), 16'h00FF);
        chk("rst_an", 16'(an0), 16'h000F);
        chk("rst_tick", 16'(tick0), 16'h0000);
        chk("rst_seg_hi", 16'(seg2), 16'h0000);

        // Scan walk: each digit held 3 cycles, tick on first edge and on the wrap.
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            ea = ~(4'b0001 << (k / 3));
            case (k / 3)
                0: es = 8'h99;
                1: es = 8'h0D;
                2: es = 8'h25;
                default: es = 8'h9F;
            endcase
            chk("walk_tick", 16'(tick0), 16'(k == 0 || k == 11));
            chk("walk_an", 16'(an0), 16'(ea));
            chk("walk_seg", 16'(seg0), 16'(es));
        end

        // Mid-frame input change must wait for the next snapshot.
        digits = 16'h1111;
        wait_tick();
        wait_an(4'b1101);
        digits = 16'h2222;
        wait_an(4'b1011);
        chk("frz_d2", 16'(seg0), 16'h009F);
        wait_an(4'b0111);
        chk("frz_d3", 16'(seg0), 16'h009F);
        wait_tick();
        chk("frz_wrap_an", 16'(an0), 16'h0007);
        chk("frz_wrap_seg", 16'(seg0), 16'h009F);
        @(negedge clk);
        chk("new_d0_an", 16'(an0), 16'h000E);
        chk("new_d0_seg", 16'(seg0), 16'h0025);

        // Leading-zero blanking on and off.
        digits = 16'h0070;
        blank_lz = 1'b1;
        wait_tick();
        wait_an(4'b1110);
        chk("lz_d0", 16'(seg0), 16'h0003);
        wait_an(4'b1101);
        chk("lz_d1", 16'(seg0), 16'h001F);
        wait_an(4'b1011);
        chk("lz_d2", 16'(seg0), 16'h00FF);
        wait_an(4'b0111);
        chk("lz_d3", 16'(seg0), 16'h00FF);
        blank_lz = 1'b0;
        wait_tick();
        wait_an(4'b1110);
        chk("nolz_d0", 16'(seg0), 16'h0003);
        wait_an(4'b1101);
        chk("nolz_d1", 16'(seg0), 16'h001F);
        wait_an(4'b1011);
        chk("nolz_d2", 16'(seg0), 16'h0003);
        wait_an(4'b0111);
        chk("nolz_d3", 16'(seg0), 16'h0003);

        // Code 4'hA: blank in decimal mode, 'A' in hex mode, dp independent.
        digits = 16'h000A;
        dp_mask = 4'b0001;
        wait_tick();
        wait_an(4'b1110);
        chk("a_dp_dec", 16'(seg0), 16'h00FE);
        chk("a_dp_hex", 16'(seg1), 16'h0010);
        chk("a_dp_hi", 16'(seg2), 16'h00EF);
        dp_mask = 4'b0000;
        wait_tick();
        wait_an(4'b1110);
        chk("a_dec", 16'(seg0), 16'h00FF);
        chk("a_hex", 16'(seg1), 16'h0011);
        chk("a_hi", 16'(seg2), 16'h00EE);

        // Disable for 10 cycles one cycle into a slot; slot finishes after re-enable.
        wait_tick();
        wait_an(4'b1110);
        en = 1'b0;
        @(negedge clk);
        chk("dis_seg", 16'(seg0), 16'h00FF);
        chk("dis_an", 16'(an0), 16'h000F);
        chk("dis_an_hi", 16'(an2), 16'h0000);
        repeat (9) @(negedge clk);
        chk("dis_hold_an", 16'(an0), 16'h000F);
        en = 1'b1;
        @(negedge clk);
        chk("res_an0", 16'(an0), 16'h000E);
        @(negedge clk);
        chk("res_an1", 16'(an0), 16'h000E);
        @(negedge clk);
        chk("res_an2", 16'(an0), 16'h000D);

        // One-cycle reset mid-frame restarts at digit 0 with a fresh snapshot.
        wait_an(4'b1011);
        digits = 16'h5678;
        rst_n = 1'b0;
        @(negedge clk);
        chk("mrst_seg", 16'(seg0), 16'h00FF);
        chk("mrst_an", 16'(an0), 16'h000F);
        chk("mrst_tick", 16'(tick0), 16'h0000);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mrst_rel_tick", 16'(tick0), 16'h0001);
        chk("mrst_rel_an", 16'(an0), 16'h000E);
        chk("mrst_rel_seg", 16'(seg0), 16'h0001);

        // Random traffic with occasional enable gaps; the scoreboard checks every cycle.
        for (int r = 0; r < 10; r++) begin
            digits = 16'($urandom);
            dp_mask = 4'($urandom);
            blank_lz = 1'($urandom);
            en = ($urandom_range(0, 4) != 0);
            repeat ($urandom_range(2, 15)) @(negedge clk);
        end
        en = 1'b1;
        repeat (30) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
